set_region_counter: RTL and testbench

- Parametrised successor to the 2015 SET grid-counting block.
- Counts integer lattice points (x,y), x,y in 1..GRID, that satisfy a set expression over three circles A, B and C.
- Adds configurable grid size, coordinate width and points evaluated per cycle (LANES), plus a 3-bit mode with eight set expressions.
- Keeps the same busy/en/valid handshake as the current block, so existing benches and integration logic carry over.

---
 rtl/set_region_counter.sv | 233 +++++++++++++++++++++++
 tb/tb_set_region_counter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_region_counter.sv
// set_region_counter
// Counts lattice points (x,y), x,y in 1..GRID, whose membership in three
// circles A, B, C satisfies one of eight set expressions chosen by mode.
// A job is accepted from IDLE (or from the DONE cycle) with en, scanned
// row-major LANES points per cycle, and reported with a one-cycle valid.
module set_region_counter #(
  parameter int CW    = 4,
  parameter int GRID  = 8,
  parameter int LANES = 1,
  parameter int OW    = $clog2(GRID*GRID+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [6*CW-1:0]   central,
  input  logic [3*CW-1:0]   radius,
  input  logic [2:0]        mode,
  output logic              busy,
  output logic              valid,
  output logic [OW-1:0]     candidate
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Scan counter bounds: x walks in steps of LANES, last group starts at GRID-LANES+1.
  localparam logic [CW-1:0] COORD_ONE = CW'(1);
  localparam logic [CW-1:0] X_STEP    = CW'(LANES);
  localparam logic [CW-1:0] X_LAST    = CW'(GRID - LANES + 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(GRID);

  // Point-in-circle test; widths chosen so no intermediate can overflow.
  function automatic logic in_circle(
    input logic [CW-1:0] px,
    input logic [CW-1:0] py,
    input logic [CW-1:0] cx,
    input logic [CW-1:0] cy,
    input logic [CW-1:0] rr
  );
    logic signed [CW:0]     dx;
    logic signed [CW:0]     dy;
    logic signed [2*CW+1:0] dxe;
    logic signed [2*CW+1:0] dye;
    logic signed [2*CW+1:0] sqx;
    logic signed [2*CW+1:0] sqy;
    logic        [2*CW+2:0] dist2;
    logic        [2*CW-1:0] rsq;
    logic        [2*CW+2:0] rad2;
    dx    = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy    = $signed({1'b0, py}) - $signed({1'b0, cy});
    dxe   = {{(CW+1){dx[CW]}}, dx};
    dye   = {{(CW+1){dy[CW]}}, dy};
    sqx   = dxe * dxe;
    sqy   = dye * dye;
    dist2 = {1'b0, sqx} + {1'b0, sqy};
    rsq   = {{CW{1'b0}}, rr} * {{CW{1'b0}}, rr};
    rad2  = {3'b000, rsq};
    return (dist2 <= rad2);
  endfunction

  // Set expression over the three memberships, selected by mode.
  function automatic logic mode_pass(
    input logic [2:0] m,
    input logic       a,
    input logic       b,
    input logic       c
  );
    logic pass;
    pass = 1'b0;
    case (m)
      3'd0:    pass = a;
      3'd1:    pass = a | b;
      3'd2:    pass = a ^ b;
      3'd3:    pass = (a & b & ~c) | (a & ~b & c) | (~a & b & c);
      3'd4:    pass = a & b & c;
      3'd5:    pass = a | b | c;
      3'd6:    pass = a & b & ~c;
      3'd7:    pass = a & ~b;
      default: pass = 1'b0;
    endcase
    return pass;
  endfunction

  state_t              r_state;
  state_t              w_state_nx;
  logic [6*CW-1:0]     r_central;
  logic [3*CW-1:0]     r_radius;
  logic [2:0]          r_mode;
  logic [CW-1:0]       r_x;
  logic [CW-1:0]       r_y;
  logic [OW-1:0]       r_acc;
  logic [OW-1:0]       r_candidate;
  logic                r_busy;
  logic                r_valid;
  logic                w_accept;
  logic                w_last;
  logic [OW-1:0]       w_hits;
  logic [OW-1:0]       w_acc_sum;
  logic [CW-1:0]       w_px;
  logic                w_a;
  logic                w_b;
  logic                w_c;

  // Latched circle parameters, xA/rA in the most significant fields.
  logic [CW-1:0] w_xa, w_ya, w_xb, w_yb, w_xc, w_yc;
  logic [CW-1:0] w_ra, w_rb, w_rc;
  assign w_xa = r_central[6*CW-1 -: CW];
  assign w_ya = r_central[5*CW-1 -: CW];
  assign w_xb = r_central[4*CW-1 -: CW];
  assign w_yb = r_central[3*CW-1 -: CW];
  assign w_xc = r_central[2*CW-1 -: CW];
  assign w_yc = r_central[CW-1 -: CW];
  assign w_ra = r_radius[3*CW-1 -: CW];
  assign w_rb = r_radius[2*CW-1 -: CW];
  assign w_rc = r_radius[CW-1 -: CW];

  // A new job may start from IDLE or from the DONE cycle (back-to-back).
  assign w_accept  = en & ((r_state == ST_IDLE) | (r_state == ST_DONE));
  assign w_last    = (r_x == X_LAST) & (r_y == Y_LAST);
  assign w_acc_sum = r_acc + w_hits;

  // Count the lanes of the current x group whose point passes the expression.
  always_comb begin
    w_hits = {OW{1'b0}};
    w_px   = {CW{1'b0}};
    w_a    = 1'b0;
    w_b    = 1'b0;
    w_c    = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      w_px = r_x + CW'(l);
      w_a  = in_circle(w_px, r_y, w_xa, w_ya, w_ra);
      w_b  = in_circle(w_px, r_y, w_xb, w_yb, w_rb);
      w_c  = in_circle(w_px, r_y, w_xc, w_yc, w_rc);
      if (mode_pass(r_mode, w_a, w_b, w_c)) begin
        w_hits = w_hits + OW'(1);
      end else begin
        w_hits = w_hits;
      end
    end
  end

  // Next-state logic: IDLE -> SCAN -> DONE -> IDLE (or straight back to SCAN).
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_state_nx = ST_SCAN;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (w_last) begin
          w_state_nx = ST_DONE;
        end else begin
          w_state_nx = ST_SCAN;
        end
      end
      ST_DONE: begin
        if (en) begin
          w_state_nx = ST_SCAN;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Status outputs registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_state_nx == ST_SCAN);
      r_valid <= (w_state_nx == ST_DONE);
    end
  end

  // Job latch, scan counters, accumulator and held result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_central   <= {(6*CW){1'b0}};
      r_radius    <= {(3*CW){1'b0}};
      r_mode      <= 3'd0;
      r_x         <= COORD_ONE;
      r_y         <= COORD_ONE;
      r_acc       <= {OW{1'b0}};
      r_candidate <= {OW{1'b0}};
    end else if (w_accept) begin
      r_central <= central;
      r_radius  <= radius;
      r_mode    <= mode;
      r_x       <= COORD_ONE;
      r_y       <= COORD_ONE;
      r_acc     <= {OW{1'b0}};
    end else if (r_state == ST_SCAN) begin
      r_acc <= w_acc_sum;
      if (r_x == X_LAST) begin
        r_x <= COORD_ONE;
        r_y <= r_y + COORD_ONE;
      end else begin
        r_x <= r_x + X_STEP;
      end
      if (w_last) begin
        r_candidate <= w_acc_sum;
      end else begin
        r_candidate <= r_candidate;
      end
    end else begin
      r_acc <= r_acc;
    end
  end

  assign busy      = r_busy;
  assign valid     = r_valid;
  assign candidate = r_candidate;

endmodule

// File: tb/tb_set_region_counter.sv
// Directed bench for set_region_counter: default geometry plus a 4-lane
// and a 16x16 two-lane instance, all with hand-computed expected counts.
module tb_set_region_counter;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // Default instance: CW=4, GRID=8, LANES=1
  logic        en0;
  logic [23:0] central0;
  logic [11:0] radius0;
  logic [2:0]  mode0;
  logic        busy0, valid0;
  logic [6:0]  candidate0;

  // Four-lane instance: CW=4, GRID=8, LANES=4
  logic        en1;
  logic [23:0] central1;
  logic [11:0] radius1;
  logic [2:0]  mode1;
  logic        busy1, valid1;
  logic [6:0]  candidate1;

  // Larger instance: CW=5, GRID=16, LANES=2
  logic        en2;
  logic [29:0] central2;
  logic [14:0] radius2;
  logic [2:0]  mode2;
  logic        busy2, valid2;
  logic [8:0]  candidate2;

  set_region_counter #(.CW(4), .GRID(8), .LANES(1), .OW(7)) dut0 (
    .clk(clk), .rst(rst), .en(en0), .central(central0), .radius(radius0),
    .mode(mode0), .busy(busy0), .valid(valid0), .candidate(candidate0)
  );

  set_region_counter #(.CW(4), .GRID(8), .LANES(4), .OW(7)) dut1 (
    .clk(clk), .rst(rst), .en(en1), .central(central1), .radius(radius1),
    .mode(mode1), .busy(busy1), .valid(valid1), .candidate(candidate1)
  );

  set_region_counter #(.CW(5), .GRID(16), .LANES(2), .OW(9)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .central(central2), .radius(radius2),
    .mode(mode2), .busy(busy2), .valid(valid2), .candidate(candidate2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a job to dut0 at a negedge; returns at the negedge after accept edge T.
  task automatic launch0(input logic [23:0] c, input logic [11:0] r, input logic [2:0] m);
    @(negedge clk);
    central0 = c;
    radius0  = r;
    mode0    = m;
    en0      = 1'b1;
    @(negedge clk);
    en0 = 1'b0;
  endtask

  // Watch a dut0 job from T+1 to T+65; optionally disturb inputs or chain a job.
  task automatic observe0(input string nm, input int exp, input bit meddle,
                          input bit chain, input logic [23:0] nc,
                          input logic [11:0] nr, input logic [2:0] nmode);
    int badcyc;
    badcyc = 0;
    for (int k = 1; k <= 64; k++) begin
      if (busy0 !== 1'b1 || valid0 !== 1'b0) badcyc++;
      if (meddle) begin
        en0      = (k < 60) ? k[0] : 1'b0;
        central0 = 24'(k * 12345);
        mode0    = 3'(k);
      end
      if (chain && k == 64) begin
        en0      = 1'b1;
        central0 = nc;
        radius0  = nr;
        mode0    = nmode;
      end
      @(negedge clk);
    end
    total++;
    if (badcyc !== 0) begin
      bad++;
      $display("FAIL %s_scan_window: %0d cycles with busy!=1 or valid!=0, want 0", nm, badcyc);
    end
    total++;
    if (valid0 !== 1'b1 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL %s_done_flags: valid=%b busy=%b, want valid=1 busy=0", nm, valid0, busy0);
    end
    total++;
    if (candidate0 !== 7'(exp)) begin
      bad++;
      $display("FAIL %s_count: got %0d, want %0d", nm, candidate0, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en0 = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (busy0 !== 1'b0 || valid0 !== 1'b0 || candidate0 !== 7'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b valid=%b cand=%0d, want 0 0 0", busy0, valid0, candidate0);
    end
    total++;
    if (candidate1 !== 7'd0 || candidate2 !== 9'd0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL reset_other: cand1=%0d cand2=%0d busy1=%b busy2=%b, want 0", candidate1, candidate2, busy1, busy2);
    end
    rst = 1'b0;
    en0 = 1'b0;
    @(negedge clk);
    total++;
    if (busy0 !== 1'b0) begin
      bad++;
      $display("FAIL reset_wins_en: busy=%b, want 0", busy0);
    end
  endtask

  task automatic test_basic();
    launch0({4'd4, 4'd4, 16'd0}, {4'd2, 8'd0}, 3'd0);
    observe0("basic", 13, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
    repeat (10) @(negedge clk);
    total++;
    if (candidate0 !== 7'd13 || valid0 !== 1'b0 || busy0 !== 1'b0) begin
      bad++;
      $display("FAIL basic_hold: cand=%0d valid=%b busy=%b, want 13 0 0", candidate0, valid0, busy0);
    end
  endtask

  task automatic test_edges();
    launch0({4'd1, 4'd1, 16'd0}, {4'd3, 8'd0}, 3'd0);
    observe0("clip_corner", 11, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
    launch0({4'd4, 4'd4, 16'd0}, {4'd15, 8'd0}, 3'd0);
    observe0("full_grid", 64, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
    launch0({4'd9, 4'd9, 16'd0}, {4'd0, 8'd0}, 3'd0);
    observe0("outside_r0", 0, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
  endtask

  task automatic test_modes_disjoint();
    launch0({4'd2, 4'd2, 4'd6, 4'd6, 4'd8, 4'd1}, {4'd1, 4'd1, 4'd0}, 3'd1);
    observe0("mode1_or", 10, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
    launch0({4'd2, 4'd2, 4'd6, 4'd6, 4'd8, 4'd1}, {4'd1, 4'd1, 4'd0}, 3'd2);
    observe0("mode2_xor", 10, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
    launch0({4'd2, 4'd2, 4'd6, 4'd6, 4'd8, 4'd1}, {4'd1, 4'd1, 4'd0}, 3'd6);
    observe0("mode6_abnc", 0, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
  endtask

  task automatic test_modes_same();
    launch0({6{4'd4}}, {3{4'd2}}, 3'd4);
    observe0("mode4_and3", 13, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
    launch0({6{4'd4}}, {3{4'd2}}, 3'd3);
    observe0("mode3_two", 0, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
    launch0({6{4'd4}}, {3{4'd2}}, 3'd5);
    observe0("mode5_or3", 13, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
    launch0({6{4'd4}}, {3{4'd2}}, 3'd7);
    observe0("mode7_anb", 0, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
  endtask

  task automatic test_handshake();
    int stray;
    launch0({4'd4, 4'd4, 16'd0}, {4'd2, 8'd0}, 3'd0);
    observe0("meddle", 13, 1'b1, 1'b0, 24'd0, 12'd0, 3'd0);
    stray = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy0 !== 1'b0 || valid0 !== 1'b0) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL meddle_no_second_job: %0d busy/valid cycles, want 0", stray);
    end
  endtask

  task automatic test_reset_mid_scan();
    int stray;
    launch0({4'd4, 4'd4, 16'd0}, {4'd2, 8'd0}, 3'd0);
    repeat (28) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy0 !== 1'b0 || valid0 !== 1'b0 || candidate0 !== 7'd0) begin
      bad++;
      $display("FAIL midscan_reset: busy=%b valid=%b cand=%0d, want 0 0 0", busy0, valid0, candidate0);
    end
    rst = 1'b0;
    stray = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (valid0 !== 1'b0 || busy0 !== 1'b0 || candidate0 !== 7'd0) stray++;
    end
    total++;
    if (stray !== 0) begin
      bad++;
      $display("FAIL midscan_aborted: %0d cycles with activity, want 0", stray);
    end
    launch0({4'd1, 4'd1, 16'd0}, {4'd3, 8'd0}, 3'd0);
    observe0("after_reset", 11, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
  endtask

  task automatic test_back_to_back();
    launch0({4'd4, 4'd4, 16'd0}, {4'd2, 8'd0}, 3'd0);
    observe0("b2b_first", 13, 1'b0, 1'b1, {4'd4, 4'd4, 16'd0}, {4'd15, 8'd0}, 3'd0);
    @(negedge clk);
    en0 = 1'b0;
    observe0("b2b_second", 64, 1'b0, 1'b0, 24'd0, 12'd0, 3'd0);
  endtask

  task automatic test_lanes();
    int badcyc;
    // Four lanes: 16 scan cycles, valid at T+17
    @(negedge clk);
    central1 = {4'd4, 4'd4, 16'd0};
    radius1  = {4'd2, 8'd0};
    mode1    = 3'd0;
    en1      = 1'b1;
    @(negedge clk);
    en1 = 1'b0;
    badcyc = 0;
    for (int k = 1; k <= 16; k++) begin
      if (busy1 !== 1'b1 || valid1 !== 1'b0) badcyc++;
      @(negedge clk);
    end
    total++;
    if (badcyc !== 0 || valid1 !== 1'b1 || busy1 !== 1'b0) begin
      bad++;
      $display("FAIL lanes4_timing: bad scan cycles=%0d valid=%b busy=%b, want 0 1 0", badcyc, valid1, busy1);
    end
    total++;
    if (candidate1 !== 7'd13) begin
      bad++;
      $display("FAIL lanes4_count: got %0d, want 13", candidate1);
    end
    // 16x16 grid, two lanes: 128 scan cycles, valid at T+129
    @(negedge clk);
    central2 = {5'd8, 5'd8, 20'd0};
    radius2  = {5'd3, 10'd0};
    mode2    = 3'd0;
    en2      = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    badcyc = 0;
    for (int k = 1; k <= 128; k++) begin
      if (busy2 !== 1'b1 || valid2 !== 1'b0) badcyc++;
      @(negedge clk);
    end
    total++;
    if (badcyc !== 0 || valid2 !== 1'b1 || busy2 !== 1'b0) begin
      bad++;
      $display("FAIL grid16_timing: bad scan cycles=%0d valid=%b busy=%b, want 0 1 0", badcyc, valid2, busy2);
    end
    total++;
    if (candidate2 !== 9'd29) begin
      bad++;
      $display("FAIL grid16_count: got %0d, want 29", candidate2);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    en0      = 1'b0;
    central0 = 24'd0;
    radius0  = 12'd0;
    mode0    = 3'd0;
    en1      = 1'b0;
    central1 = 24'd0;
    radius1  = 12'd0;
    mode1    = 3'd0;
    en2      = 1'b0;
    central2 = 30'd0;
    radius2  = 15'd0;
    mode2    = 3'd0;
    test_reset();
    test_basic();
    test_edges();
    test_modes_disjoint();
    test_modes_same();
    test_handshake();
    test_reset_mid_scan();
    test_back_to_back();
    test_lanes();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
